oht_debug_shifter: RTL

Debug-side driver for the serial debug pins of the OHT/SRAM mux: it generates the bit stream that is injected into one SRAM input bit, and it captures the bit stream from the selected OHT output into a 32-bit word. One instance serves the latch OHT/SRAM path and another serves the jitter OHT/SRAM path. It sits between the mux's serial pins and the debug register file, and runs at a programmable bit interval so that slow external observers can follow the stream.

---
 rtl/oht_debug_shifter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/oht_debug_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : oht_debug_shifter
//  Description : Debug-side serial driver for the OHT/SRAM mux debug pins.
//                Injects a 32-bit pattern (LSB first) onto one SRAM input
//                bit, or captures 32 bits from the selected OHT output, at a
//                programmable number of clocks per bit. One instance serves
//                the latch path, another serves the jitter path.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1      system clock, rising edge
//    rst_n          in   1      asynchronous active-low reset
//    debug          in   1      debug enable; low forces the block idle
//    start          in   1      transfer request, accepted in IDLE only
//    mode           in   1      0 = capture, 1 = inject (latched at start)
//    pattern        in   32     inject pattern, LSB first (latched at start)
//    interval       in   DIV_W  clocks per bit minus one (latched at start)
//    oht_mux_in     in   1      serial data from the mux OHT output
//    sram_mux_out   out  1      serial data to the mux SRAM input
//    busy           out  1      transfer in progress
//    done           out  1      one-cycle pulse on normal completion
//    capture_word   out  32     captured bits, LSB = first bit sampled
//    capture_valid  out  1      capture_word holds a complete capture
//    ones_count     out  6      number of 1s captured (0..32)
// ============================================================================
module oht_debug_shifter #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             debug,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      pattern,
    input  logic [DIV_W-1:0] interval,
    input  logic             oht_mux_in,
    output logic             sram_mux_out,
    output logic             busy,
    output logic             done,
    output logic [31:0]      capture_word,
    output logic             capture_valid,
    output logic [5:0]       ones_count
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [4:0] c_LAST_BIT = 5'd31;

    logic [1:0]       r_state;
    logic             r_mode_q;
    logic [31:0]      r_pattern_q;
    logic [DIV_W-1:0] r_interval_q;
    logic [DIV_W-1:0] r_div_cnt;
    logic [4:0]       r_bit_cnt;
    logic             r_sram_out;
    logic [31:0]      r_capture_word;
    logic             r_capture_valid;
    logic [5:0]       r_ones_count;

    logic             w_tick;
    logic [4:0]       w_bit_nxt;

    assign w_tick    = (r_div_cnt == r_interval_q);
    assign w_bit_nxt = r_bit_cnt + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= c_ST_IDLE;
            r_mode_q        <= 1'b0;
            r_pattern_q     <= '0;
            r_interval_q    <= '0;
            r_div_cnt       <= '0;
            r_bit_cnt       <= '0;
            r_sram_out      <= 1'b0;
            r_capture_word  <= '0;
            r_capture_valid <= 1'b0;
            r_ones_count    <= '0;
        end else if (!debug) begin
            // Debug withdrawn: abandon any transfer. Capture results keep
            // whatever partial shift they hold; capture_valid was already
            // cleared when the capture started.
            r_state    <= c_ST_IDLE;
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_sram_out <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state      <= c_ST_RUN;
                        r_mode_q     <= mode;
                        r_pattern_q  <= pattern;
                        r_interval_q <= interval;
                        r_div_cnt    <= '0;
                        r_bit_cnt    <= '0;
                        // Pin output is registered, so bit 0 is loaded here
                        // to appear on the first RUN cycle.
                        r_sram_out   <= mode & pattern[0];
                        if (!mode) begin
                            r_capture_valid <= 1'b0;
                            r_ones_count    <= '0;
                        end
                    end
                end

                c_ST_RUN: begin
                    if (w_tick) begin
                        r_div_cnt <= '0;
                        r_bit_cnt <= w_bit_nxt;
                        if (!r_mode_q) begin
                            r_capture_word <= {oht_mux_in, r_capture_word[31:1]};
                            r_ones_count   <= r_ones_count + {5'd0, oht_mux_in};
                        end
                        if (r_bit_cnt == c_LAST_BIT) begin
                            r_state    <= c_ST_DONE;
                            r_sram_out <= 1'b0;
                            // Set on the final tick so capture_valid rises
                            // together with the done pulse.
                            if (!r_mode_q) begin
                                r_capture_valid <= 1'b1;
                            end
                        end else begin
                            r_sram_out <= r_mode_q & r_pattern_q[w_bit_nxt];
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state    <= c_ST_IDLE;
                    r_sram_out <= 1'b0;
                end
            endcase
        end
    end

    assign sram_mux_out  = r_sram_out;
    assign busy          = (r_state == c_ST_RUN);
    assign done          = (r_state == c_ST_DONE);
    assign capture_word  = r_capture_word;
    assign capture_valid = r_capture_valid;
    assign ones_count    = r_ones_count;

endmodule
`default_nettype wire
